// File: rtl/toast_pkg.sv
// Shared types and constants for the Toast fetch path.
package toast_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect input, IMEM read port and the decode valid/ready port.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import toast_pkg::*;

  logic                         Redirect;
  logic [XLEN-1:0]              Redirect_pc;
  logic [XLEN-1:0]              IMEM_addr;
  logic                         IMEM_rd_en;
  logic [INSTR_W-1:0]           IMEM_data;
  logic                         Out_valid;
  logic                         Out_ready;
  logic [XLEN-1:0]              Out_pc;
  logic [INSTR_W-1:0]           Out_instr;
  logic [$clog2(DEPTH+1)-1:0]   Count;

  modport master (
    input  Redirect, Redirect_pc, IMEM_data, Out_ready,
    output IMEM_addr, IMEM_rd_en, Out_valid, Out_pc, Out_instr, Count
  );

  modport slave (
    output Redirect, Redirect_pc, IMEM_data, Out_ready,
    input  IMEM_addr, IMEM_rd_en, Out_valid, Out_pc, Out_instr, Count
  );
endinterface

// File: rtl/toast_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head is read combinationally.
module toast_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IMEM (1-cycle read) and decode (valid/ready).
// Optional FETCH_QUEUE_BYPASS_EN forwards the in-flight response straight to decode when empty.
module fetch_queue
  import toast_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + INSTR_W;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [EW-1:0]   head_dat;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     occupancy;
  logic            live, bypass, out_valid, pop_any, issue;
  logic            fifo_push, fifo_pop;

  // Reset is treated like a redirect for the combinational outputs of this cycle.
  assign live      = Reset_n && !bus.Redirect;
  assign occupancy = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass        = (fifo_cnt == '0) && inflight_q;
  assign bus.Out_pc    = bypass ? inflight_pc_q : head_dat[EW-1:INSTR_W];
  assign bus.Out_instr = bypass ? bus.IMEM_data : head_dat[INSTR_W-1:0];
`else
  assign bypass        = 1'b0;
  assign bus.Out_pc    = head_dat[EW-1:INSTR_W];
  assign bus.Out_instr = head_dat[INSTR_W-1:0];
`endif

  assign out_valid = live && ((fifo_cnt != '0) || bypass);
  assign pop_any   = out_valid && bus.Out_ready;
  assign fifo_pop  = pop_any && (fifo_cnt != '0);
  // A bypassed response that decode takes immediately never occupies a slot.
  assign fifo_push = live && inflight_q && !(bypass && bus.Out_ready);
  // Credit counts the in-flight response, so a capture can never overflow.
  assign issue     = live && ((occupancy < DEPTH_OCC) ||
                              ((occupancy == DEPTH_OCC) && pop_any));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (bus.Redirect) begin
      fetch_pc_d = {bus.Redirect_pc[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  toast_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .push_i     (fifo_push),
    .push_dat_i ({inflight_pc_q, bus.IMEM_data}),
    .pop_i      (fifo_pop),
    .flush_i    (bus.Redirect),
    .head_dat_o (head_dat),
    .count_o    (fifo_cnt)
  );

  assign bus.IMEM_addr  = fetch_pc_q;
  assign bus.IMEM_rd_en = issue;
  assign bus.Out_valid  = out_valid;
  assign bus.Count      = fifo_cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios plus random traffic against a queue-based reference model of the fetch queue.
module tb_fetch_queue;
  import toast_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // IMEM: returns addr+0x1000 one cycle after a request, junk otherwise.
  logic        s_rd;
  logic [31:0] s_addr;
  always @(negedge Clk) begin
    s_rd   <= bus.IMEM_rd_en;
    s_addr <= bus.IMEM_addr;
  end
  always @(posedge Clk) begin
    if (s_rd === 1'b1) bus.IMEM_data <= s_addr + 32'h1000;
    else               bus.IMEM_data <= $urandom;
  end

  // Reference model: a queue of delivered-but-not-consumed entries, one pending request, a fetch PC.
  fetch_entry_t m_q[$];
  bit           m_known = 0;
  bit           m_pend  = 0;
  logic [31:0]  m_pend_pc = '0;
  logic [31:0]  m_fpc = '0;

  function automatic void model_exp(output bit v, output bit rd, output bit byp);
    int occ;
    bit live;
    occ  = m_q.size() + int'(m_pend);
    live = Reset_n && !bus.Redirect;
    byp  = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp  = (m_q.size() == 0) && m_pend;
`endif
    v  = live && (m_q.size() != 0 || byp);
    rd = live && (occ < DEPTH || (occ == DEPTH && v && bus.Out_ready));
  endfunction

  // Compare on the falling edge, then advance the model to the upcoming rising edge.
  always @(negedge Clk) begin
    bit v, rd, byp;
    fetch_entry_t e;
    if (m_known) begin
      model_exp(v, rd, byp);
      check("out_valid", bus.Out_valid, v);
      check("imem_rd_en", bus.IMEM_rd_en, rd);
      check("imem_addr", bus.IMEM_addr, m_fpc);
      check("count", bus.Count, m_q.size());
      if (v) begin
        if (m_q.size() != 0) e = m_q[0];
        else e = '{pc: m_pend_pc, instr: m_pend_pc + 32'h1000};
        check("out_pc", bus.Out_pc, e.pc);
        check("out_instr", bus.Out_instr, e.instr);
      end
    end
    if (!Reset_n) begin
      m_known = 1;
      m_q.delete();
      m_pend = 0;
      m_pend_pc = '0;
      m_fpc = RESET_PC;
    end else if (m_known) begin
      if (bus.Redirect) begin
        m_q.delete();
        m_pend = 0;
        m_fpc = bus.Redirect_pc & ~32'h3;
      end else begin
        model_exp(v, rd, byp);
        if (v && bus.Out_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (m_pend && !(byp && bus.Out_ready))
          m_q.push_back('{pc: m_pend_pc, instr: m_pend_pc + 32'h1000});
        if (rd) begin
          m_pend = 1;
          m_pend_pc = m_fpc;
          m_fpc = m_fpc + 32'd4;
        end else begin
          m_pend = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    Reset_n = 1'b0;
    bus.Redirect = 1'b0;
    bus.Out_ready = rdy;
    cyc();
    Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    int first_valid, pulses, n, bad, max_cnt;
    logic [31:0] dl[$];
    logic [31:0] fa[$];
    logic [31:0] wrap_exp [4];

    bus.Redirect = 1'b0;
    bus.Redirect_pc = '0;
    bus.Out_ready = 1'b1;
    Reset_n = 1'b0;
    cyc();
    cyc();
    #1;
    check("rst_valid", bus.Out_valid, 0);
    check("rst_rd_en", bus.IMEM_rd_en, 0);
    check("rst_addr", bus.IMEM_addr, RESET_PC);
    check("rst_count", bus.Count, 0);
    check("rst_pc", bus.Out_pc, 0);
    check("rst_instr", bus.Out_instr, 0);

    // Streaming with decode always ready.
    Reset_n = 1'b1;
    first_valid = -1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.IMEM_rd_en) pulses++;
      if (c == 3) check("stream_addr3", bus.IMEM_addr, 32'hC);
      if (bus.Out_valid && first_valid < 0) first_valid = c;
      if (c == LAT) begin
        check("stream_pc_first", bus.Out_pc, 32'h0);
        check("stream_instr_first", bus.Out_instr, 32'h1000);
      end
      if (c == LAT + 3) check("stream_pc_later", bus.Out_pc, 32'hC);
      cyc();
    end
    check("stream_first_valid", first_valid, LAT);
    check("stream_rd_pulses", pulses, 12);

    // Decode stalled from reset: fill to DEPTH, then drain.
    do_reset(1'b0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.IMEM_rd_en) pulses++;
      cyc();
    end
    #1;
    check("full_pulses", pulses, 4);
    check("full_count", bus.Count, 4);
    check("full_rd_en", bus.IMEM_rd_en, 0);
    bus.Out_ready = 1'b1;
    #1;
    check("full_rd_reassert", bus.IMEM_rd_en, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("drain_valid", bus.Out_valid, 1);
      check("drain_pc", bus.Out_pc, 32'(4 * k));
      cyc();
    end

    // Redirect with 3 queued and 1 in flight.
    do_reset(1'b0);
    repeat (4) cyc();
    #1;
    check("pre_redir_count", bus.Count, 3);
    check("pre_redir_rd_en", bus.IMEM_rd_en, 0);
    bus.Redirect = 1'b1;
    bus.Redirect_pc = 32'h203;
    #1;
    check("redir_valid_gate", bus.Out_valid, 0);
    check("redir_rd_gate", bus.IMEM_rd_en, 0);
    cyc();
    bus.Redirect = 1'b0;
    bus.Out_ready = 1'b1;
    #1;
    check("redir_addr", bus.IMEM_addr, 32'h200);
    check("redir_count", bus.Count, 0);
    check("redir_rd_en", bus.IMEM_rd_en, 1);
    first_valid = -1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        cyc();
        #1;
      end
      if (bus.Out_valid && first_valid < 0) begin
        first_valid = c;
        check("redir_first_pc", bus.Out_pc, 32'h200);
      end
    end
    check("redir_latency", first_valid, LAT + 1);

    // Back-to-back redirects: only the second target is fetched.
    do_reset(1'b1);
    repeat (3) cyc();
    bus.Redirect = 1'b1;
    bus.Redirect_pc = 32'h100;
    cyc();
    bus.Redirect_pc = 32'h300;
    cyc();
    bus.Redirect = 1'b0;
    dl.delete();
    fa.delete();
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.IMEM_rd_en) fa.push_back(bus.IMEM_addr);
      if (bus.Out_valid && bus.Out_ready) dl.push_back(bus.Out_pc);
      cyc();
    end
    bad = 0;
    foreach (fa[i]) if (fa[i] >= 32'h100 && fa[i] < 32'h200) bad++;
    foreach (dl[i]) if (dl[i] >= 32'h100 && dl[i] < 32'h200) bad++;
    check("dbl_redir_stale", bad, 0);
    check("dbl_redir_fetch0", (fa.size() > 0) ? fa[0] : 32'hDEAD_DEAD, 32'h300);
    check("dbl_redir_deliv0", (dl.size() > 0) ? dl[0] : 32'hDEAD_DEAD, 32'h300);

    // PC wrap with toggling ready.
    do_reset(1'b1);
    bus.Redirect = 1'b1;
    bus.Redirect_pc = 32'hFFFF_FFF8;
    cyc();
    bus.Redirect = 1'b0;
    dl.delete();
    max_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.Out_ready = (c % 2 == 0);
      #1;
      if (bus.Out_valid && bus.Out_ready) dl.push_back(bus.Out_pc);
      if (int'(bus.Count) > max_cnt) max_cnt = int'(bus.Count);
      cyc();
    end
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0;
    wrap_exp[3] = 32'h4;
    n = dl.size();
    for (int i = 0; i < 4; i++)
      check("wrap_order", (i < n) ? dl[i] : 32'hDEAD_DEAD, wrap_exp[i]);
    check("wrap_count_bound", (max_cnt > DEPTH), 0);

    // Single-cycle reset pulse mid-stream.
    do_reset(1'b1);
    repeat (6) cyc();
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    #1;
    check("pulse_count", bus.Count, 0);
    check("pulse_valid", bus.Out_valid, 0);
    check("pulse_addr", bus.IMEM_addr, RESET_PC);
    check("pulse_rd_en", bus.IMEM_rd_en, 1);
    repeat (4) cyc();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.Out_ready   = ($urandom_range(0, 9) < 6);
      bus.Redirect    = ($urandom_range(0, 31) == 0);
      bus.Redirect_pc = $urandom;
      Reset_n         = ($urandom_range(0, 299) != 0);
      cyc();
    end
    Reset_n = 1'b1;
    bus.Redirect = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
